// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory controller: splits each 32-bit load/store into two
// 16-bit SRAM accesses (low halfword, then high) with programmable wait states.
module mem_stage_sram_ctrl #(
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        is_wr_q, is_wr_d;
    logic [16:0] wa_q, wa_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] read_data_q, read_data_d;
    logic        phase_last;
    logic        in_access;

    assign phase_last = (cnt_q == CNT_LAST);
    assign in_access  = (state_q == ST_LO) || (state_q == ST_HI);

    // NOTE: every variable written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_wr_d     = is_wr_q;
        wa_d        = wa_q;
        wdata_d     = wdata_q;
        read_data_d = read_data_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_en || wr_en) begin
                    state_d = ST_LO;
                    is_wr_d = wr_en;
                    // Wrapping subtraction: addresses below BASE_ADDR alias high.
                    wa_d    = 17'((address - BASE_ADDR) >> 2);
                    wdata_d = write_data;
                    cnt_d   = 4'd0;
                end
            end
            ST_LO: begin
                if (phase_last) begin
                    cnt_d   = 4'd0;
                    state_d = ST_HI;
                    if (!is_wr_q) read_data_d[15:0] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_HI: begin
                if (phase_last) begin
                    cnt_d   = 4'd0;
                    state_d = ST_DONE;
                    if (!is_wr_q) read_data_d[31:16] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            is_wr_q     <= 1'b0;
            wa_q        <= 17'd0;
            wdata_q     <= 32'd0;
            read_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_wr_q     <= is_wr_d;
            wa_q        <= wa_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
        end
    end

    // Bus outputs decode straight from state so a reset clears them at once.
    always_comb begin
        sram_addr   = 18'd0;
        sram_dq_out = 16'd0;
        case (state_q)
            ST_LO: begin
                sram_addr   = {wa_q, 1'b0};
                sram_dq_out = wdata_q[15:0];
            end
            ST_HI: begin
                sram_addr   = {wa_q, 1'b1};
                sram_dq_out = wdata_q[31:16];
            end
            default: ;
        endcase
    end

    assign sram_dq_oe = in_access && is_wr_q;
    assign sram_we_n  = !(in_access && is_wr_q);
    assign read_data  = read_data_q;
    assign ready      = (state_q == ST_DONE) ||
                        ((state_q == ST_IDLE) && !rd_en && !wr_en);

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Scoreboard bench: two controllers (W=1 and W=0) on a shared SRAM model; the
// stimulus queues expected bus beats and completions, a monitor pops them.
module tb_mem_stage_sram_ctrl;

    typedef struct packed {
        logic        beat;
        logic [17:0] addr;
        logic [15:0] data;
        logic [31:0] rdata;
        logic        chk_rd;
        logic [7:0]  lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  rd_en, wr_en, rdy, we_n, oe;
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic [31:0] rdata  [2];
    logic [17:0] sa     [2];
    logic [15:0] dq_out [2];
    logic [15:0] dq_in  [2];
    logic [15:0] mem    [64];

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   checks = 0;
    int   errors = 0;
    int   busy[2] = '{0, 0};
    logic [1:0] prev_rdy = 2'b11;

    mem_stage_sram_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) dut0 (
        .clk(clk), .rst(rst), .rd_en(rd_en[0]), .wr_en(wr_en[0]),
        .address(addr[0]), .write_data(wdata[0]), .read_data(rdata[0]),
        .ready(rdy[0]), .sram_addr(sa[0]), .sram_dq_out(dq_out[0]),
        .sram_dq_in(dq_in[0]), .sram_dq_oe(oe[0]), .sram_we_n(we_n[0])
    );

    mem_stage_sram_ctrl #(.WAIT_CYCLES(0), .BASE_ADDR(32'd1024)) dut1 (
        .clk(clk), .rst(rst), .rd_en(rd_en[1]), .wr_en(wr_en[1]),
        .address(addr[1]), .write_data(wdata[1]), .read_data(rdata[1]),
        .ready(rdy[1]), .sram_addr(sa[1]), .sram_dq_out(dq_out[1]),
        .sram_dq_in(dq_in[1]), .sram_dq_oe(oe[1]), .sram_we_n(we_n[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dq_in[0] = mem[sa[0][5:0]];
    assign dq_in[1] = mem[sa[1][5:0]];

    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++)
                if (!we_n[i]) mem[sa[i][5:0]] <= dq_out[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic q_push(input int idx, input exp_t e);
        if (idx == 0) exp_q0.push_back(e);
        else          exp_q1.push_back(e);
    endtask

    task automatic q_pop(input int idx, output exp_t e, output logic ok);
        ok = 1'b0;
        e  = '0;
        if (idx == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); ok = 1'b1; end
        if (idx == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); ok = 1'b1; end
    endtask

    task automatic push_write(input int idx, input logic [17:0] lo, input logic [31:0] d,
                              input logic [7:0] lat);
        int w;
        w = (idx == 0) ? 1 : 0;
        repeat (w + 1) q_push(idx, '{1'b1, lo, d[15:0], 32'h0, 1'b0, 8'd0});
        repeat (w + 1) q_push(idx, '{1'b1, lo + 18'd1, d[31:16], 32'h0, 1'b0, 8'd0});
        q_push(idx, '{1'b0, 18'd0, 16'd0, 32'h0, 1'b0, lat});
    endtask

    task automatic push_read(input int idx, input logic [31:0] rd, input logic [7:0] lat);
        q_push(idx, '{1'b0, 18'd0, 16'd0, rd, 1'b1, lat});
    endtask

    task automatic mon_step(input int idx, input logic r, input logic rd_y, input logic wn,
                            input logic o, input logic [17:0] a, input logic [15:0] dq,
                            input logic [31:0] rd);
        exp_t e;
        logic ok;
        if (!r) begin
            busy[idx]     = 0;
            prev_rdy[idx] = rd_y;
            return;
        end
        if (!wn || o) begin
            q_pop(idx, e, ok);
            checks++;
            if (!ok || !e.beat || a !== e.addr || dq !== e.data || wn !== 1'b0 || o !== 1'b1) begin
                errors++;
                $display("FAIL beat dut%0d: addr=%h dq=%h we_n=%b oe=%b expected addr=%h dq=%h we_n=0 oe=1 (queued=%0b beat=%0b)",
                         idx, a, dq, wn, o, e.addr, e.data, ok, e.beat);
            end
        end
        if (!rd_y) begin
            busy[idx]++;
        end else if (!prev_rdy[idx]) begin
            q_pop(idx, e, ok);
            checks++;
            if (!ok || e.beat || busy[idx] != int'(e.lat) || (e.chk_rd && rd !== e.rdata)) begin
                errors++;
                $display("FAIL done dut%0d: latency=%0d read_data=%h expected latency=%0d read_data=%h (queued=%0b beat=%0b)",
                         idx, busy[idx], rd, e.lat, e.rdata, ok, e.beat);
            end
            busy[idx] = 0;
        end
        prev_rdy[idx] = rd_y;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon_step(0, rst, rdy[0], we_n[0], oe[0], sa[0], dq_out[0], rdata[0]);
            mon_step(1, rst, rdy[1], we_n[1], oe[1], sa[1], dq_out[1], rdata[1]);
        end
    end

    task automatic issue(input int idx, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        rd_en[idx] = rd;
        wr_en[idx] = wr;
        addr[idx]  = a;
        wdata[idx] = d;
        @(posedge clk); #1;
        rd_en[idx] = 1'b0;
        wr_en[idx] = 1'b0;
    endtask

    task automatic wait_done(input int idx);
        int n;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (rdy[idx]) break;
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL timeout dut%0d: ready still 0 after 40 cycles, expected 1", idx);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b0;
        rd_en = 2'b00;
        wr_en = 2'b00;
        for (int i = 0; i < 2; i++) begin
            addr[i]  = 32'h0;
            wdata[i] = 32'h0;
        end
        for (int i = 0; i < 64; i++) mem[i] = 16'h0;
        mem[4]  = 16'hBEEF;
        mem[5]  = 16'hDEAD;
        mem[10] = 16'h3C3C;
        mem[11] = 16'hC3C3;

        // Reset: ready follows the idle rule while held.
        @(negedge clk);
        check("rst_ready", {31'd0, rdy[0]}, 32'd1);
        check("rst_read_data", rdata[0], 32'h0);
        check("rst_we_n", {31'd0, we_n[0]}, 32'd1);
        check("rst_sram_addr", {14'd0, sa[0]}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        repeat (10) begin
            @(negedge clk);
            check("idle_ready", {30'd0, rdy}, 32'd3);
            check("idle_we_n", {30'd0, we_n}, 32'd3);
            check("idle_oe", {30'd0, oe}, 32'd0);
        end

        // W=1 write and reads.
        push_write(0, 18'd4, 32'hDEADBEEF, 8'd5);
        issue(0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF);
        wait_done(0);

        push_read(0, 32'hDEADBEEF, 8'd5);
        issue(0, 1'b1, 1'b0, 32'd1032, 32'h0);
        wait_done(0);

        push_read(0, 32'hC3C33C3C, 8'd5);
        issue(0, 1'b1, 1'b0, 32'd1044, 32'h0);
        wait_done(0);

        // Address below base wraps to the top of the SRAM.
        push_write(0, 18'h3FFFE, 32'h0BADF00D, 8'd5);
        issue(0, 1'b0, 1'b1, 32'd1020, 32'h0BADF00D);
        wait_done(0);

        // W=0: both enables behave as a write, then read it back.
        push_write(1, 18'd0, 32'h12345678, 8'd3);
        issue(1, 1'b1, 1'b1, 32'd1024, 32'h12345678);
        wait_done(1);

        push_read(1, 32'h12345678, 8'd3);
        issue(1, 1'b1, 1'b0, 32'd1024, 32'h0);
        wait_done(1);

        // Input changes mid-transaction are ignored.
        push_read(0, 32'hDEADBEEF, 8'd5);
        issue(0, 1'b1, 1'b0, 32'd1032, 32'h0);
        wr_en[0] = 1'b1;
        addr[0]  = 32'h0;
        wdata[0] = 32'hFFFFFFFF;
        @(posedge clk);
        @(posedge clk); #1;
        wr_en[0] = 1'b0;
        wait_done(0);

        // Request held through DONE is consumed; still held in IDLE starts another.
        push_read(0, 32'hDEADBEEF, 8'd5);
        push_read(0, 32'hC3C33C3C, 8'd5);
        @(posedge clk); #1;
        rd_en[0] = 1'b1;
        addr[0]  = 32'd1032;
        wait_done(0);
        addr[0] = 32'd1044;
        @(posedge clk);
        @(posedge clk); #1;
        rd_en[0] = 1'b0;
        wait_done(0);

        // Reset during the high half of a write.
        q_push(0, '{1'b1, 18'd4, 16'hF00D, 32'h0, 1'b0, 8'd0});
        q_push(0, '{1'b1, 18'd4, 16'hF00D, 32'h0, 1'b0, 8'd0});
        q_push(0, '{1'b1, 18'd5, 16'hCAFE, 32'h0, 1'b0, 8'd0});
        issue(0, 1'b0, 1'b1, 32'd1032, 32'hCAFEF00D);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_we_n", {31'd0, we_n[0]}, 32'd1);
        check("abort_oe", {31'd0, oe[0]}, 32'd0);
        check("abort_read_data", rdata[0], 32'h0);
        check("abort_sram_addr", {14'd0, sa[0]}, 32'h0);
        check("abort_dq_out", {16'd0, dq_out[0]}, 32'h0);
        check("abort_ready", {31'd0, rdy[0]}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {30'd0, rdy}, 32'd3);

        // Only the low halfword of the aborted write reached the SRAM.
        push_read(0, 32'hDEADF00D, 8'd5);
        issue(0, 1'b1, 1'b0, 32'd1032, 32'h0);
        wait_done(0);

        repeat (3) @(negedge clk);
        check("q0_drained", exp_q0.size(), 32'd0);
        check("q1_drained", exp_q1.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
